// File: rtl/fsm_ctrl_ti_param_if.sv
// Bus bundle for fsm_ctrl_ti_param: control inputs, Mealy outputs and
// the trigger observation signals. The master drives x; the controller
// (slave) drives y, trig and cnt.
interface fsm_ctrl_ti_param_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 4
);
  logic [IN_W-1:0]  x;
  logic [OUT_W-1:0] y;
  logic             trig;
  logic [CNT_W-1:0] cnt;

  modport master (output x, input y, input trig, input cnt);
  modport slave  (input x, output y, output trig, output cnt);
endinterface

// File: rtl/fsm_ctrl_ti_param.sv
// Six-state Mealy control FSM with a parametrised rare-event trigger.
// A RUN->CHK transition whose qualifier x[IN_W-1:4] matches TRIG_PAT
// counts as an event; once the count reaches THRESH a sticky armed flag
// switches on one of two payloads (divert CHK->DONE to ERR, or invert y[0]).
module fsm_ctrl_ti_param #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 5,
  parameter int MODE    = 0,
  parameter int PAYLOAD = 0,
  parameter logic [((IN_W > 4) ? IN_W - 4 : 1)-1:0] TRIG_PAT = '1
) (
  input  logic               clk,
  input  logic               rst,
  fsm_ctrl_ti_param_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             armed_nxt;
  logic             match;
  logic             event_hit;
  logic [5:0]       y_core;

  // With no qualifier bits every event counts as a match.
  generate
    if (IN_W == 4) begin : g_nomatch
      assign match = 1'b1;
    end else begin : g_match
      assign match = (bus.x[IN_W-1:4] == TRIG_PAT);
    end
  endgenerate

  assign event_hit = (state == RUN) && bus.x[3];

  // State, trigger counter and armed flag all advance on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= armed_nxt;
    end
  end

  // Counter update: saturating count of matching events; in consecutive
  // mode a non-matching event restarts the run. Armed never clears here.
  always_comb begin
    cnt_nxt   = cnt;
    armed_nxt = armed;
    if (event_hit) begin
      if (match) begin
        if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (MODE == 1) begin
        cnt_nxt = '0;
      end
    end
    if (cnt_nxt >= THRESH_V) begin
      armed_nxt = 1'b1;
    end
  end

  // Mealy next-state and output decode, with the armed payload applied last.
  always_comb begin
    state_nxt = state;
    y_core    = '0;
    case (state)
      IDLE: begin
        if (bus.x[0]) begin
          state_nxt = LOAD;
          y_core[0] = 1'b1;
        end
      end
      LOAD: begin
        if (bus.x[1]) begin
          state_nxt = RUN;
          y_core[1] = 1'b1;
        end else if (bus.x[2]) begin
          state_nxt = ERR;
          y_core[5] = 1'b1;
        end
      end
      RUN: begin
        if (bus.x[3]) begin
          state_nxt = CHK;
          y_core[2] = 1'b1;
        end
      end
      CHK: begin
        if (bus.x[2]) begin
          if ((PAYLOAD == 0) && armed) begin
            state_nxt = ERR;
            y_core[5] = 1'b1;
          end else begin
            state_nxt = DONE;
            y_core[3] = 1'b1;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        y_core[4] = 1'b1;
      end
      ERR: begin
        if (!bus.x[0]) begin
          state_nxt = IDLE;
        end else begin
          y_core[5] = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if ((PAYLOAD == 1) && armed) begin
      y_core[0] = ~y_core[0];
    end
  end

  // Drive the bus; output bits above 5 are always zero.
  always_comb begin
    bus.y      = '0;
    bus.y[5:0] = y_core;
  end

  assign bus.trig = armed;
  assign bus.cnt  = cnt;

endmodule

// File: tb/tb_fsm_ctrl_ti_param.sv
// Testbench for fsm_ctrl_ti_param: four instances cover the default
// configuration, payload 1, consecutive mode and a 2-bit saturating counter.
module tb_fsm_ctrl_ti_param;

  typedef struct {
    int         dut;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] cnt;
    logic       trig;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] x_d   [4];
  logic [7:0] y_s   [4];
  logic [3:0] cnt_s [4];
  logic       trig_s[4];

  vec_t vec[$];
  vec_t sb[$];
  int   compared;
  int   mismatched;

  fsm_ctrl_ti_param_if #(.IN_W(8), .OUT_W(8), .CNT_W(4)) if0 ();
  fsm_ctrl_ti_param_if #(.IN_W(8), .OUT_W(8), .CNT_W(4)) if1 ();
  fsm_ctrl_ti_param_if #(.IN_W(8), .OUT_W(8), .CNT_W(4)) if2 ();
  fsm_ctrl_ti_param_if #(.IN_W(8), .OUT_W(8), .CNT_W(2)) if3 ();

  fsm_ctrl_ti_param #(.MODE(0), .PAYLOAD(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  fsm_ctrl_ti_param #(.MODE(0), .PAYLOAD(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  fsm_ctrl_ti_param #(.MODE(1), .PAYLOAD(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
  fsm_ctrl_ti_param #(.CNT_W(2), .THRESH(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.x = x_d[0];
  assign if1.x = x_d[1];
  assign if2.x = x_d[2];
  assign if3.x = x_d[3];

  assign y_s[0] = if0.y;
  assign y_s[1] = if1.y;
  assign y_s[2] = if2.y;
  assign y_s[3] = if3.y;

  assign cnt_s[0] = if0.cnt;
  assign cnt_s[1] = if1.cnt;
  assign cnt_s[2] = if2.cnt;
  assign cnt_s[3] = {2'b00, if3.cnt};

  assign trig_s[0] = if0.trig;
  assign trig_s[1] = if1.trig;
  assign trig_s[2] = if2.trig;
  assign trig_s[3] = if3.trig;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic [7:0] xv, input logic [7:0] yv,
                     input logic [3:0] c, input logic t);
    vec_t r;
    r.dut  = d;
    r.x    = xv;
    r.y    = yv;
    r.cnt  = c;
    r.trig = t;
    vec.push_back(r);
  endtask

  // Called just after a rising edge: drive x and queue the expectation.
  task automatic apply_stimulus(input vec_t r);
    x_d[r.dut] = r.x;
    sb.push_back(r);
  endtask

  // y is checked mid-cycle; cnt/trig after the following rising edge.
  task automatic check_output(input int idx);
    vec_t e;
    #2;
    e = sb[0];
    check($sformatf("y dut%0d step%0d", e.dut, idx), {24'd0, y_s[e.dut]}, {24'd0, e.y});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("cnt dut%0d step%0d", e.dut, idx), {28'd0, cnt_s[e.dut]}, {28'd0, e.cnt});
    check($sformatf("trig dut%0d step%0d", e.dut, idx), {31'd0, trig_s[e.dut]}, {31'd0, e.trig});
  endtask

  task automatic run_table();
    for (int i = 0; i < vec.size(); i++) begin
      apply_stimulus(vec[i]);
      check_output(i);
    end
    vec.delete();
  endtask

  task automatic add_nominal(input int d);
    add(d, 8'h01, 8'h01, 4'd0, 1'b0);
    add(d, 8'h02, 8'h02, 4'd0, 1'b0);
    add(d, 8'h08, 8'h04, 4'd0, 1'b0);
    add(d, 8'h04, 8'h08, 4'd0, 1'b0);
    add(d, 8'h00, 8'h10, 4'd0, 1'b0);
    add(d, 8'h00, 8'h00, 4'd0, 1'b0);
  endtask

  // Five matching RUN->CHK events from IDLE, ending in CHK with trig set.
  task automatic add_arm5(input int d);
    add(d, 8'h01, 8'h01, 4'd0, 1'b0);
    add(d, 8'h02, 8'h02, 4'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      add(d, 8'hF8, 8'h04, 4'(k), (k == 5));
      if (k < 5) add(d, 8'hF0, 8'h00, 4'(k), 1'b0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    for (int i = 0; i < 4; i++) x_d[i] = 8'h00;

    // Reset values, with y showing the IDLE decode of x[0].
    #2;
    x_d[0] = 8'h01;
    #1;
    check("reset y", {24'd0, y_s[0]}, 32'h01);
    check("reset cnt", {28'd0, cnt_s[0]}, 32'h0);
    check("reset trig", {31'd0, trig_s[0]}, 32'h0);
    x_d[0] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Nominal pass with a non-matching qualifier, then cumulative arming
    // and the ERR diversion on dut0.
    add_nominal(0);
    add_arm5(0);
    add(0, 8'h04, 8'h20, 4'd5, 1'b1);
    add(0, 8'h01, 8'h20, 4'd5, 1'b1);
    add(0, 8'h00, 8'h00, 4'd5, 1'b1);
    add(0, 8'h01, 8'h01, 4'd5, 1'b1);

    // Payload 1: y[0] inverted once armed, transitions unchanged.
    add(1, 8'h00, 8'h00, 4'd0, 1'b0);
    add_arm5(1);
    add(1, 8'h04, 8'h09, 4'd5, 1'b1);
    add(1, 8'h00, 8'h11, 4'd5, 1'b1);
    add(1, 8'h00, 8'h01, 4'd5, 1'b1);
    add(1, 8'h01, 8'h00, 4'd5, 1'b1);

    // Consecutive mode: 4 matches, a miss clears, 5 matches arm.
    add(2, 8'h01, 8'h01, 4'd0, 1'b0);
    add(2, 8'h02, 8'h02, 4'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      add(2, 8'hF8, 8'h04, 4'(k), 1'b0);
      add(2, 8'hF0, 8'h00, 4'(k), 1'b0);
    end
    add(2, 8'h08, 8'h04, 4'd0, 1'b0);
    add(2, 8'h00, 8'h00, 4'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      add(2, 8'hF8, 8'h04, 4'(k), (k == 5));
      if (k < 5) add(2, 8'hF0, 8'h00, 4'(k), 1'b0);
    end
    add(2, 8'hF0, 8'h00, 4'd5, 1'b1);
    add(2, 8'h08, 8'h04, 4'd0, 1'b1);

    // 2-bit counter saturates at 3 without wrapping.
    add(3, 8'h01, 8'h01, 4'd0, 1'b0);
    add(3, 8'h02, 8'h02, 4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      add(3, 8'hF8, 8'h04, 4'((k < 3) ? k : 3), (k >= 3));
      if (k < 10) add(3, 8'hF0, 8'h00, 4'((k < 3) ? k : 3), (k >= 3));
    end
    run_table();

    // Asynchronous reset while dut3 sits in CHK with trig set.
    for (int i = 0; i < 3; i++) x_d[i] = 8'h00;
    x_d[3] = 8'h01;
    #2;
    check("pre-reset chk y", {24'd0, y_s[3]}, 32'h00);
    rst = 1'b0;
    #1;
    check("async reset y", {24'd0, y_s[3]}, 32'h01);
    check("async reset cnt", {28'd0, cnt_s[3]}, 32'h0);
    check("async reset trig", {31'd0, trig_s[3]}, 32'h0);
    check("async reset trig dut0", {31'd0, trig_s[0]}, 32'h0);
    check("async reset cnt dut0", {28'd0, cnt_s[0]}, 32'h0);
    @(posedge clk);
    #1;
    check("held reset y", {24'd0, y_s[3]}, 32'h01);
    x_d[3] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // After reset: nominal pass on dut3 and LOAD->ERR on dut0.
    add_nominal(3);
    add(0, 8'h01, 8'h01, 4'd0, 1'b0);
    add(0, 8'h04, 8'h20, 4'd0, 1'b0);
    add(0, 8'h01, 8'h20, 4'd0, 1'b0);
    add(0, 8'h05, 8'h20, 4'd0, 1'b0);
    add(0, 8'h00, 8'h00, 4'd0, 1'b0);
    add(0, 8'h00, 8'h00, 4'd0, 1'b0);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl_ti_param.md
# fsm_ctrl_ti_param

Parametrised successor to the team's fixed-width trust-benchmark controllers. It contains a 6-state Mealy control FSM and a configurable rare-event trigger counter. The counter arms a sticky trigger that alters the FSM's behaviour through one of two selectable payloads. Widths, threshold, counting mode and payload are set by parameters. The block sits in the benchmark suite as a golden, detectable-trigger reference for insertion and detection flows.

## Interface
- IN_W, 8: input vector width, ≥4; x[3:0] drive the FSM, x[IN_W-1:4] form the trigger qualifier.
- OUT_W, 8: output vector width, ≥6; bits above 5 are tied to 0.
- CNT_W, 4: trigger counter width.
- THRESH, 5: arming threshold, 1..2^CNT_W-1.
- MODE, 0: 0 = cumulative count; 1 = consecutive count.
- PAYLOAD, 0: 0 = divert the CHK→DONE path to ERR; 1 = invert y[0].
- TRIG_PAT, all-ones: qualifier pattern, width max(IN_W-4,1); ignored when IN_W=4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- x  in  IN_W  control inputs.
- y  out  OUT_W  Mealy outputs; combinational from state, x and armed.
- trig  out  1  armed flag; registered.
- cnt  out  CNT_W  trigger counter value; registered.

## Operation
- State encoding: IDLE=0, LOAD=1, RUN=2, CHK=3, DONE=4, ERR=5.
- Codes 6 and 7 are illegal. They drive y=0 and next state IDLE.
- y defaults to 0 in every state; only the listed bits are set.
- IDLE: if x[0], go to LOAD and set y[0]. Otherwise stay in IDLE.
- LOAD: if x[1], go to RUN and set y[1]. Else if x[2], go to ERR and set y[5]. Otherwise stay in LOAD.
- RUN: if x[3], go to CHK and set y[2]. Otherwise stay in RUN.
- CHK: if x[2], go to DONE and set y[3]. Otherwise return to RUN.
- DONE: go to IDLE unconditionally and set y[4].
- ERR: if x[0]=0, go to IDLE. Otherwise stay in ERR and set y[5].
- Event: a RUN→CHK transition.
  - match: x[IN_W-1:4]==TRIG_PAT at that transition, or IN_W=4.
- MODE 0: each matching event increments cnt. Non-matching events do nothing.
- MODE 1: a matching event increments cnt. A non-matching event clears cnt to 0.
- cnt saturates at 2^CNT_W-1 and never wraps.
- armed is sticky. It is set on the edge where cnt's next value is ≥THRESH. Only rst clears it. trig = armed.
- Once armed, cnt keeps counting and saturating. In MODE 1, clearing cnt does not clear armed.
- Payload 0, armed: CHK with x[2]=1 goes to ERR and sets y[5] instead of y[3]. All other behaviour is unchanged.
- Payload 1, armed: y[0] is inverted in every state, including illegal codes. Transitions are unchanged.
- Reset values: state=IDLE, cnt=0, trig=0. During reset y = {0…, x[0]} (the IDLE decode with armed=0).

## Timing
- Next state, cnt and armed update on the same rising edge.
- trig goes high in the cycle after the edge that carries the THRESH-th counted event.
  - The payload affects y combinationally from that cycle onward.
- y responds to x within the same cycle, with no register stage.
- rst is asserted asynchronously and forces reset values immediately. It is deasserted synchronously; the first update occurs on the first rising edge with rst=1.
- Reset mid-operation in any state, including with armed=1, returns to the full reset values.

## Test plan
- Nominal pass (defaults, x[7:4]=0): apply x[3:0] = 0001, 0010, 1000, 0100, then 0000.
  - Required y: 0x01, 0x02, 0x04, 0x08, then 0x10, then IDLE.
  - Required cnt: stays 0, because the pattern does not match.
- MODE 0, THRESH=5: run 5 loops of RUN→CHK→RUN with x[7:4]=1111.
  - Required: cnt=1..5, trig=1 after the 5th edge.
  - Then: CHK with x[2]=1 goes to ERR, y=0x20.
  - Same test with PAYLOAD=1: IDLE with x=0 gives y=0x01.
- MODE 1, THRESH=5: 4 matching events, 1 non-matching, then 5 matching.
  - Required: cnt 4→0, then climbs to 5; trig rises only after the last event.
- Saturation, CNT_W=2, THRESH=3: 10 matching events.
  - Required: cnt sticks at 3, trig=1, no wrap to 0.
- Async reset: assert rst low mid-clock while in CHK with trig=1.
  - Required: state=IDLE, cnt=0, trig=0 immediately, with no clock edge.
  - The nominal pass works after rst is released.
- LOAD→ERR: apply x=0100 in LOAD.
  - Required: ERR, y=0x20; it holds while x[0]=1 and returns to IDLE on x[0]=0.
